// File: rtl/mem_ctrl_if.sv
// Host request/response and memory strobe/address signals of mem_ctrl.
// A request transfers on a rising edge with req_valid && req_ready; rsp_valid is a one-cycle completion pulse with no back-pressure.
interface mem_ctrl_if;
   logic        req_valid;
   logic        req_wr;
   logic [5:0]  req_addr;
   logic [63:0] req_wdata;
   logic        req_ready;
   logic        rsp_valid;
   logic [63:0] rsp_data;
   logic        wr_err;
   logic        mem_wr;
   logic        mem_rd;
   logic [5:0]  addr;

   modport master (
      output req_valid, req_wr, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_data, wr_err, mem_wr, mem_rd, addr
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_data, wr_err, mem_wr, mem_rd, addr
   );
endinterface

// File: rtl/mem_ctrl.sv
// Single-port memory controller: setup/strobe/hold access sequencing on a shared tristate data bus.
// Optional write-verify read-back is enabled by defining MEM_CTRL_WRVERIFY_EN.
module mem_ctrl #(
   parameter int STROBE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   mem_ctrl_if.slave   host,
   inout  wire  [63:0] data_bus,
   output logic [2:0]  state_dbg,
   output logic        bus_drive
);

`ifdef MEM_CTRL_WRVERIFY_EN
   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN, VSETUP, VSTROBE, VHOLD} state_t;
`else
   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;
`endif

   localparam logic [3:0] LAST = 4'(STROBE_CYCLES - 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        wr_q;
   logic [5:0]  addr_q;
   logic [63:0] wdata_q;
   logic        accept;
   logic        last_strobe;

   assign accept      = (state == IDLE) && host.req_valid;
   assign last_strobe = (cnt == LAST);
   assign state_dbg   = state;
   assign data_bus    = bus_drive ? wdata_q : 64'bz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Request fields are frozen at acceptance so the host may change them freely afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         wr_q    <= host.req_wr;
         addr_q  <= host.req_addr;
         wdata_q <= host.req_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         host.rsp_data <= '0;
      end else if ((state == STROBE) && !wr_q && last_strobe) begin
         host.rsp_data <= data_bus;
      end
   end

`ifdef MEM_CTRL_WRVERIFY_EN
   logic verify_pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         verify_pending <= 1'b0;
         host.wr_err    <= 1'b0;
      end else begin
         if ((state == HOLD) && wr_q) verify_pending <= 1'b1;
         else if (state == VHOLD)     verify_pending <= 1'b0;
         if ((state == VSTROBE) && last_strobe) host.wr_err <= (data_bus != wdata_q);
      end
   end
`else
   assign host.wr_err = 1'b0;
`endif

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      host.req_ready = 1'b0;
      host.rsp_valid = 1'b0;
      host.mem_wr    = 1'b0;
      host.mem_rd    = 1'b0;
      host.addr      = '0;
      bus_drive      = 1'b0;
      case (state)
         IDLE: begin
            host.req_ready = 1'b1;
            if (host.req_valid) state_nxt = SETUP;
         end
         SETUP: begin
            host.addr = addr_q;
            bus_drive = wr_q;
            cnt_nxt   = '0;
            state_nxt = STROBE;
         end
         STROBE: begin
            host.addr   = addr_q;
            host.mem_wr = wr_q;
            host.mem_rd = !wr_q;
            bus_drive   = wr_q;
            if (last_strobe) state_nxt = HOLD;
            else             cnt_nxt   = cnt + 4'd1;
         end
         HOLD: begin
            host.addr = addr_q;
            bus_drive = wr_q;
`ifdef MEM_CTRL_WRVERIFY_EN
            host.rsp_valid = !wr_q;
`else
            host.rsp_valid = 1'b1;
`endif
            state_nxt = TURN;
         end
         // Bus-released cycle separating any two accesses.
         TURN: begin
            host.addr = addr_q;
`ifdef MEM_CTRL_WRVERIFY_EN
            state_nxt = verify_pending ? VSETUP : IDLE;
`else
            state_nxt = IDLE;
`endif
         end
`ifdef MEM_CTRL_WRVERIFY_EN
         VSETUP: begin
            host.addr = addr_q;
            cnt_nxt   = '0;
            state_nxt = VSTROBE;
         end
         VSTROBE: begin
            host.addr   = addr_q;
            host.mem_rd = 1'b1;
            if (last_strobe) state_nxt = VHOLD;
            else             cnt_nxt   = cnt + 4'd1;
         end
         VHOLD: begin
            host.addr      = addr_q;
            host.rsp_valid = 1'b1;
            state_nxt      = TURN;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: table vectors, randomized traffic against a word-array model,
// and hand-written reset, back-to-back and strobe-width sequences.
module tb_mem_ctrl;
   localparam int N = 2;
`ifdef MEM_CTRL_WRVERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   typedef struct packed {
      logic       ready;
      logic       valid;
      logic       wr;
      logic       rd;
      logic       drive;
      logic [5:0] addr;
   } obs_t;

   typedef struct {
      logic        wr;
      logic [5:0]  addr;
      logic [63:0] wdata;
      logic [63:0] exp_rdata;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_ctrl_if h ();
   mem_ctrl_if h1 ();
   mem_ctrl_if h15 ();
   wire [63:0] bus, bus1, bus15;
   logic [2:0] st, st1, st15;
   logic drv, drv1, drv15;

   mem_ctrl #(.STROBE_CYCLES(N))  dut   (.clk(clk), .rst_n(rst_n), .host(h.slave),   .data_bus(bus),   .state_dbg(st),   .bus_drive(drv));
   mem_ctrl #(.STROBE_CYCLES(1))  dut1  (.clk(clk), .rst_n(rst_n), .host(h1.slave),  .data_bus(bus1),  .state_dbg(st1),  .bus_drive(drv1));
   mem_ctrl #(.STROBE_CYCLES(15)) dut15 (.clk(clk), .rst_n(rst_n), .host(h15.slave), .data_bus(bus15), .state_dbg(st15), .bus_drive(drv15));

   // Memory device: drives the bus while read-strobed, stores on write strobe edges.
   logic [63:0] mem [64];
   logic        stuck0;
   assign bus = h.mem_rd ? (mem[h.addr] & ~{63'b0, stuck0}) : 64'bz;
   always @(posedge clk) if (h.mem_wr) mem[h.addr] <= bus;

   int n_vec  = 0;
   int n_miss = 0;
   int overlap = 0;
   logic [63:0] ref_mem [64];
   logic [63:0] last_rd;
   longint t_prev_acc = 0;

   always @(negedge clk) begin
      if ((h.mem_wr && h.mem_rd) || (h1.mem_wr && h1.mem_rd) || (h15.mem_wr && h15.mem_rd)) overlap++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic obs_t obs_now();
      obs_t o;
      o.ready = h.req_ready;
      o.valid = h.rsp_valid;
      o.wr    = h.mem_wr;
      o.rd    = h.mem_rd;
      o.drive = drv;
      o.addr  = h.addr;
      return o;
   endfunction

   // Expected observation k cycles after the acceptance edge.
   function automatic obs_t expect_at(input logic wr, input logic [5:0] a, input int k);
      obs_t o;
      o = '0;
      o.addr = a;
      if (k == 1) o.drive = wr;
      else if (k <= N + 1) begin o.wr = wr; o.rd = !wr; o.drive = wr; end
      else if (k == N + 2) begin o.drive = wr; o.valid = !(VERIFY && wr); end
      else if (k == N + 3) o.drive = 1'b0;
      else if (k == N + 4) o.drive = 1'b0;
      else if (k <= 2 * N + 4) o.rd = 1'b1;
      else if (k == 2 * N + 5) o.valid = 1'b1;
      return o;
   endfunction

   task automatic access(input logic wr, input logic [5:0] a, input logic [63:0] d,
                         input logic [63:0] exp_rsp, input logic exp_err, input bit hold,
                         input logic nwr, input logic [5:0] na, input logic [63:0] nd, input bit check_gap);
      int last_k;
      longint t_acc;
      obs_t o_exp;
      if (!h.req_valid) begin
         h.req_wr = wr; h.req_addr = a; h.req_wdata = d; h.req_valid = 1'b1;
      end
      for (int g = 0; g < 20 && !h.req_ready; g++) @(negedge clk);
      check("ready", {63'b0, h.req_ready}, 64'd1);
      @(posedge clk);
      t_acc = longint'($time);
      if (check_gap) check("accept_gap", 64'((t_acc - t_prev_acc) / 10), 64'(N + 4));
      t_prev_acc = t_acc;
      last_k = (VERIFY && wr) ? 2 * N + 6 : N + 3;
      for (int k = 1; k <= last_k; k++) begin
         @(negedge clk);
         if (k == 2) begin
            h.req_valid = hold; h.req_wr = nwr; h.req_addr = na; h.req_wdata = nd;
         end
         o_exp = expect_at(wr, a, k);
         check($sformatf("timeline k=%0d", k), {53'b0, obs_now()}, {53'b0, o_exp});
         if (o_exp.valid) begin
            check("rsp_data", h.rsp_data, exp_rsp);
            if (wr) check("wr_err", {63'b0, h.wr_err}, {63'b0, exp_err});
         end
      end
   endtask

   task automatic single(input logic wr, input logic [5:0] a, input logic [63:0] d,
                         input logic [63:0] exp_rsp, input logic exp_err);
      access(wr, a, d, exp_rsp, exp_err, 1'b0, ~wr, ~a, ~d, 1'b0);
   endtask

   task automatic model_op(input logic wr, input logic [5:0] a, input logic [63:0] d);
      logic [63:0] e;
      e = wr ? last_rd : ref_mem[a];
      single(wr, a, d, e, 1'b0);
      if (wr) ref_mem[a] = d;
      else    last_rd = e;
   endtask

   task automatic measure_rd(input int sel, output int width);
      width = 0;
      @(negedge clk);
      if (sel == 1) begin h1.req_wr = 1'b0; h1.req_addr = 6'h07; h1.req_valid = 1'b1; end
      else          begin h15.req_wr = 1'b0; h15.req_addr = 6'h07; h15.req_valid = 1'b1; end
      @(negedge clk);
      h1.req_valid = 1'b0;
      h15.req_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if ((sel == 1) ? h1.mem_rd : h15.mem_rd) width++;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [9];
      int w1, w15, seen;
      vecs[0] = '{1'b1, 6'h3F, 64'h00000000DEADBEEF, 64'h0};
      vecs[1] = '{1'b0, 6'h3F, 64'h0,                64'h00000000DEADBEEF};
      vecs[2] = '{1'b1, 6'h00, 64'h0123456789ABCDEF, 64'h0};
      vecs[3] = '{1'b1, 6'h01, 64'hFFFFFFFFFFFFFFFF, 64'h0};
      vecs[4] = '{1'b0, 6'h00, 64'h0,                64'h0123456789ABCDEF};
      vecs[5] = '{1'b0, 6'h01, 64'h0,                64'hFFFFFFFFFFFFFFFF};
      vecs[6] = '{1'b0, 6'h20, 64'h0,                64'h0};
      vecs[7] = '{1'b1, 6'h3F, 64'h0,                64'h0};
      vecs[8] = '{1'b0, 6'h3F, 64'h0,                64'h0};

      rst_n = 1'b0; stuck0 = 1'b0; last_rd = '0;
      for (int i = 0; i < 64; i++) begin mem[i] = '0; ref_mem[i] = '0; end
      h.req_valid = 1'b0; h.req_wr = 1'b0; h.req_addr = '0; h.req_wdata = '0;
      h1.req_valid = 1'b0; h1.req_wr = 1'b0; h1.req_addr = '0; h1.req_wdata = '0;
      h15.req_valid = 1'b0; h15.req_wr = 1'b0; h15.req_addr = '0; h15.req_wdata = '0;
      repeat (2) @(negedge clk);
      check("reset_obs", {53'b0, obs_now()}, {53'b0, obs_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h0}});
      check("reset_rsp_data", h.rsp_data, 64'h0);
      check("reset_wr_err", {63'b0, h.wr_err}, 64'd0);
      rst_n = 1'b1;

      // Table vectors; the first is accepted on the first edge after reset release.
      for (int i = 0; i < 9; i++) begin
         single(vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].wr ? last_rd : vecs[i].exp_rdata, 1'b0);
         if (vecs[i].wr) ref_mem[vecs[i].addr] = vecs[i].wdata;
         else            last_rd = vecs[i].exp_rdata;
      end

      // Request inputs move from 0x01 to 0x02 mid-strobe; the latched address must hold.
      access(1'b0, 6'h01, 64'h0, ref_mem[1], 1'b0, 1'b0, 1'b0, 6'h02, 64'h0, 1'b0);
      last_rd = ref_mem[1];

      // Back-to-back write then read with req_valid held high.
      access(1'b1, 6'h12, 64'hA5A5_0000_1234_5678, last_rd, 1'b0, 1'b1, 1'b0, 6'h12, 64'h0, 1'b0);
      ref_mem[6'h12] = 64'hA5A5_0000_1234_5678;
      access(1'b0, 6'h12, 64'h0, ref_mem[6'h12], 1'b0, 1'b0, 1'b1, 6'h2D, 64'h0, 1'b1);
      last_rd = ref_mem[6'h12];

      for (int i = 0; i < 30; i++) begin
         model_op(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), {$urandom, $urandom});
      end

`ifdef MEM_CTRL_WRVERIFY_EN
      stuck0 = 1'b1;
      single(1'b1, 6'h10, 64'h0000_0000_0000_0001, last_rd, 1'b1);
      stuck0 = 1'b0;
      single(1'b1, 6'h10, 64'h0000_0000_0000_0003, last_rd, 1'b0);
      ref_mem[6'h10] = 64'h3;
      model_op(1'b0, 6'h10, 64'h0);
`endif

      // Reset during the strobe of a write to 0x05 aborts it silently.
      @(negedge clk);
      h.req_wr = 1'b1; h.req_addr = 6'h05; h.req_wdata = 64'hCAFE_F00D_0000_0055; h.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      h.req_valid = 1'b0;
      @(negedge clk);
      check("rst_pre_strobe", {63'b0, h.mem_wr}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_obs", {53'b0, obs_now()}, {53'b0, obs_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h0}});
      check("rst_async_rsp_data", h.rsp_data, 64'h0);
      check("rst_async_wr_err", {63'b0, h.wr_err}, 64'd0);
      last_rd = '0;
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (h.rsp_valid) seen++;
      end
      check("rst_no_rsp", 64'(seen), 64'd0);
      rst_n = 1'b1;
      model_op(1'b0, 6'h05, 64'h0);

      measure_rd(1, w1);
      measure_rd(15, w15);
      check("rd_width_1", 64'(w1), 64'd1);
      check("rd_width_15", 64'(w15), 64'd15);
      check("strobe_overlap", 64'(overlap), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter STROBE_CYCLES, default 2, SHALL set the cycles MemWr/MemRd are held high per access; legal range 1..15.
REQ-002 Clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 Rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 ReqValid  input  1  SHALL indicate that a host request is presented.
REQ-005 ReqWr  input  1  SHALL select write (1) or read (0) for the presented request.
REQ-006 ReqAddr  input  6  SHALL carry the word address, 0..63.
REQ-007 ReqWData  input  64  SHALL carry the write data.
REQ-008 ReqReady  output  1  SHALL signal that the controller can accept a request.
REQ-009 RspValid  output  1  SHALL pulse for one cycle when an access completes.
REQ-010 RspData  output  64  SHALL hold the most recent read data.
REQ-011 WrErr  output  1  SHALL flag a write-verify mismatch; it is valid while RspValid is high.
REQ-012 MemWr  output  1  SHALL be the memory write strobe.
REQ-013 MemRd  output  1  SHALL be the memory read strobe.
REQ-014 Addr  output  6  SHALL be the memory word address.
REQ-015 DataBus  inout  64  SHALL be the shared bidirectional memory data bus.

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP, STROBE, HOLD and TURN; the verify states VSETUP, VSTROBE and VHOLD exist only under REQ-033.
REQ-017 ReqReady SHALL be 1 only in IDLE; a request is accepted when ReqValid and ReqReady are both high at a rising edge.
REQ-018 On acceptance the controller SHALL latch ReqWr, ReqAddr and ReqWData; later changes on those inputs are ignored until the next acceptance.
REQ-019 Transitions SHALL be: IDLE -> SETUP on accept; SETUP -> STROBE after 1 cycle; STROBE -> HOLD after STROBE_CYCLES cycles; HOLD -> TURN after 1 cycle; TURN -> IDLE after 1 cycle.
REQ-020 Addr SHALL equal the latched address from SETUP through HOLD, and 0 in IDLE.
REQ-021 MemWr SHALL be high only in STROBE of a write, and MemRd only in STROBE of a read; the two SHALL never be high together.
REQ-022 DataBus SHALL be driven with the latched write data in SETUP, STROBE and HOLD of a write, and SHALL be high-Z in every other state.
REQ-023 Read capture: RspData SHALL load DataBus at the rising edge that ends the last STROBE cycle.
REQ-024 RspValid SHALL be high for exactly the one HOLD cycle of every access, read or write.
REQ-025 For a write, RspData SHALL be left unchanged.
REQ-026 Latency SHALL be STROBE_CYCLES+2 cycles from the acceptance edge to RspValid, and the minimum request-to-request spacing SHALL be STROBE_CYCLES+4 cycles.
REQ-027 The TURN cycle SHALL guarantee one bus-released cycle between consecutive accesses, including read after write and write after read.
REQ-028 A ReqValid held high in any state other than IDLE SHALL be ignored and not queued.

Reset
REQ-029 Asserting Rst_n low SHALL force, without waiting for Clk: state IDLE, MemWr=0, MemRd=0, Addr=0, DataBus high-Z, RspValid=0, RspData=0, WrErr=0, and all latched request registers to 0.
REQ-030 After reset, ReqReady SHALL read 1.
REQ-031 A reset asserted mid-access SHALL abort the access with no RspValid; any partial write is not reported.
REQ-032 The first request SHALL be accepted on the first rising edge after Rst_n deasserts.

Configuration
REQ-033 With MEM_CTRL_WRVERIFY_EN defined, a write SHALL take the path HOLD (no RspValid) -> TURN -> VSETUP -> VSTROBE (MemRd high, STROBE_CYCLES cycles, same Addr) -> VHOLD -> TURN -> IDLE.
REQ-034 In that mode, at the end of VSTROBE, WrErr SHALL be set to (DataBus != latched write data), and RspValid SHALL pulse in VHOLD.
REQ-035 In that mode, write latency SHALL be 2*STROBE_CYCLES+5 cycles, and read behaviour SHALL be unchanged.
REQ-036 Without MEM_CTRL_WRVERIFY_EN, the verify states SHALL be absent and WrErr SHALL be tied to 0.

Verification
REQ-037 Reset mid-STROBE of a write to 0x05: all outputs SHALL take their REQ-029 values immediately, with no RspValid.
REQ-038 Write 0x00000000DEADBEEF to 0x3F, then read 0x3F: RspData SHALL be 0x00000000DEADBEEF, with RspValid at cycle STROBE_CYCLES+2 after acceptance.
REQ-039 Back-to-back write then read with ReqValid held high: the second accept SHALL occur exactly STROBE_CYCLES+4 cycles after the first, and DataBus SHALL be high-Z during TURN.
REQ-040 STROBE_CYCLES=1 and 15: MemRd high width SHALL be 1 and 15 cycles respectively, and MemWr and MemRd SHALL never overlap.
REQ-041 Request inputs changed during STROBE (address 0x01 to 0x02): Addr SHALL stay 0x01 until IDLE.
REQ-042 With MEM_CTRL_WRVERIFY_EN defined, a write to 0x10 with the memory model forcing bit 0 stuck: WrErr SHALL be 1 with RspValid; with a correct memory model, WrErr SHALL be 0.
